// File: rtl/vector_checker.sv
// Expected-vector checker: masked per-channel compare with saturating match/mismatch
// counters, global totals, and a small run FSM with error-limit and cycle timeout exits.
module vector_checker #(
  parameter int N_CH           = 4,
  parameter int WIDTH          = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int CH_SEL_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic                    clock,
  input  logic                    reset_,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    valid,
  input  logic [N_CH*WIDTH-1:0]   dut_vec,
  input  logic [N_CH*WIDTH-1:0]   exp_vec,
  input  logic [N_CH*WIDTH-1:0]   exp_mask,
  input  logic [CNT_WIDTH-1:0]    max_err,
  input  logic [CH_SEL_WIDTH-1:0] ch_sel,
  output logic                    rd_en,
  output logic [N_CH-1:0]         mismatch,
  output logic [CNT_WIDTH-1:0]    ch_match_cnt,
  output logic [CNT_WIDTH-1:0]    ch_mismatch_cnt,
  output logic [CNT_WIDTH-1:0]    total_txn,
  output logic [CNT_WIDTH-1:0]    total_err,
  output logic [1:0]              state,
  output logic                    done,
  output logic                    timed_out,
  output logic                    fail
);

  localparam int CYC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam int NM_W = $clog2(N_CH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LIMIT = 2'd2, DONE = 2'd3} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  match_cnt_q [N_CH];
  logic [CNT_WIDTH-1:0]  match_cnt_d [N_CH];
  logic [CNT_WIDTH-1:0]  mis_cnt_q   [N_CH];
  logic [CNT_WIDTH-1:0]  mis_cnt_d   [N_CH];
  logic [CNT_WIDTH-1:0]  txn_q, txn_d, err_q, err_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic [N_CH-1:0]       mismatch_q, mismatch_d, ch_mis;
  logic                  timed_out_q, timed_out_d, fail_q, fail_d;
  logic [NM_W-1:0]       n_mis;
  logic [CNT_WIDTH:0]    err_sum;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    ch_mis = '0;
    n_mis  = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_mis[i] = |((dut_vec[i*WIDTH +: WIDTH] ^ exp_vec[i*WIDTH +: WIDTH]) & exp_mask[i*WIDTH +: WIDTH]);
      n_mis     = n_mis + NM_W'(ch_mis[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    txn_d       = txn_q;
    err_d       = err_q;
    cyc_d       = cyc_q;
    timed_out_d = timed_out_q;
    mismatch_d  = '0;
    err_sum     = '0;
    if (start) begin
      for (int i = 0; i < N_CH; i++) begin
        match_cnt_d[i] = '0;
        mis_cnt_d[i]   = '0;
      end
      txn_d       = '0;
      err_d       = '0;
      cyc_d       = '0;
      timed_out_d = 1'b0;
      state_d     = RUN;
    end else if (state_q == RUN) begin
      if (TIMEOUT_CYCLES != 0) cyc_d = cyc_q + CYC_W'(1);
      if (valid) begin
        for (int i = 0; i < N_CH; i++) begin
          if (ch_mis[i]) mis_cnt_d[i]   = sat_inc(mis_cnt_q[i]);
          else           match_cnt_d[i] = sat_inc(match_cnt_q[i]);
        end
        txn_d      = sat_inc(txn_q);
        err_sum    = {1'b0, err_q} + (CNT_WIDTH+1)'(n_mis);
        err_d      = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
        mismatch_d = ch_mis;
      end
      // The limit is judged on the post-update total so the crossing compare trips it.
      if (max_err != '0 && err_d >= max_err) begin
        state_d = LIMIT;
      end else if (TIMEOUT_CYCLES != 0 && cyc_q == CYC_LAST) begin
        state_d     = DONE;
        timed_out_d = 1'b1;
      end else if (stop) begin
        state_d = DONE;
      end
    end else if (state_q == LIMIT && stop) begin
      state_d = DONE;
    end
    fail_d = (state_d == LIMIT || state_d == DONE) && (err_d != '0);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q     <= IDLE;
      for (int i = 0; i < N_CH; i++) begin
        match_cnt_q[i] <= '0;
        mis_cnt_q[i]   <= '0;
      end
      txn_q       <= '0;
      err_q       <= '0;
      cyc_q       <= '0;
      timed_out_q <= 1'b0;
      fail_q      <= 1'b0;
      mismatch_q  <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      txn_q       <= txn_d;
      err_q       <= err_d;
      cyc_q       <= cyc_d;
      timed_out_q <= timed_out_d;
      fail_q      <= fail_d;
      mismatch_q  <= mismatch_d;
    end
  end

  always_comb begin
    ch_match_cnt    = '0;
    ch_mismatch_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_SEL_WIDTH'(i)) begin
        ch_match_cnt    = match_cnt_q[i];
        ch_mismatch_cnt = mis_cnt_q[i];
      end
    end
  end

  assign rd_en     = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign state     = state_q;
  assign mismatch  = mismatch_q;
  assign total_txn = txn_q;
  assign total_err = err_q;
  assign timed_out = timed_out_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker: a default instance plus a 4-bit-counter,
// no-timeout instance for saturation; inputs driven and outputs sampled on negedge.
module tb_vector_checker;
  logic        clock = 1'b0;
  logic        reset_, start, stop, valid;
  logic [31:0] dut_vec, exp_vec, exp_mask;
  logic [15:0] max_err;
  logic [1:0]  ch_sel;
  logic        rd_en, done, timed_out, fail;
  logic [3:0]  mismatch;
  logic [15:0] ch_match_cnt, ch_mismatch_cnt, total_txn, total_err;
  logic [1:0]  state;
  logic [3:0]  max_err_s;
  logic        rd_en_s, done_s, timed_out_s, fail_s;
  logic [3:0]  mismatch_s, ch_match_cnt_s, ch_mismatch_cnt_s, total_txn_s, total_err_s;
  logic [1:0]  state_s;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  vector_checker dut (
    .clock(clock), .reset_(reset_), .start(start), .stop(stop), .valid(valid),
    .dut_vec(dut_vec), .exp_vec(exp_vec), .exp_mask(exp_mask), .max_err(max_err),
    .ch_sel(ch_sel), .rd_en(rd_en), .mismatch(mismatch), .ch_match_cnt(ch_match_cnt),
    .ch_mismatch_cnt(ch_mismatch_cnt), .total_txn(total_txn), .total_err(total_err),
    .state(state), .done(done), .timed_out(timed_out), .fail(fail)
  );

  vector_checker #(.CNT_WIDTH(4), .TIMEOUT_CYCLES(0)) dut_s (
    .clock(clock), .reset_(reset_), .start(start), .stop(stop), .valid(valid),
    .dut_vec(dut_vec), .exp_vec(exp_vec), .exp_mask(exp_mask), .max_err(max_err_s),
    .ch_sel(ch_sel), .rd_en(rd_en_s), .mismatch(mismatch_s), .ch_match_cnt(ch_match_cnt_s),
    .ch_mismatch_cnt(ch_mismatch_cnt_s), .total_txn(total_txn_s), .total_err(total_err_s),
    .state(state_s), .done(done_s), .timed_out(timed_out_s), .fail(fail_s)
  );

  task automatic cycle();
    @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  task automatic test_reset();
    reset_ = 1'b0; start = 1'b1; stop = 1'b0; valid = 1'b1;
    dut_vec = 32'h1234_5678; exp_vec = 32'h8765_4321; exp_mask = '1;
    max_err = 16'd0; max_err_s = 4'd0; ch_sel = 2'd0;
    cycle(); cycle();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    n_cmp++; if (total_txn !== 16'd0 || total_err !== 16'd0) begin n_bad++; $display("FAIL reset_totals: got %0d/%0d want 0/0", total_txn, total_err); end
    n_cmp++; if (ch_match_cnt !== 16'd0 || ch_mismatch_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_ch_cnt: got %0d/%0d want 0/0", ch_match_cnt, ch_mismatch_cnt); end
    n_cmp++; if ({mismatch, done, timed_out, fail} !== 7'd0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000000", {mismatch, done, timed_out, fail}); end
    start = 1'b0; valid = 1'b0;
    reset_ = 1'b1; cycle();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL idle_hold: got %0d want 0", state); end
  endtask

  task automatic test_match();
    pulse_start();
    n_cmp++; if (state !== 2'd1 || rd_en !== 1'b1) begin n_bad++; $display("FAIL start_run: got state=%0d rd_en=%b want 1/1", state, rd_en); end
    for (int i = 0; i < 10; i++) begin
      valid = 1'b1; exp_vec = 32'h0101_0101 * i + 32'hA5C3_3C5A; dut_vec = exp_vec; cycle();
    end
    valid = 1'b0;
    n_cmp++; if (total_txn !== 16'd10) begin n_bad++; $display("FAIL match_txn: got %0d want 10", total_txn); end
    n_cmp++; if (total_err !== 16'd0) begin n_bad++; $display("FAIL match_err: got %0d want 0", total_err); end
    for (int c = 0; c < 4; c++) begin
      ch_sel = 2'(c); #1;
      n_cmp++; if (ch_match_cnt !== 16'd10 || ch_mismatch_cnt !== 16'd0) begin n_bad++; $display("FAIL match_ch%0d: got %0d/%0d want 10/0", c, ch_match_cnt, ch_mismatch_cnt); end
    end
    ch_sel = 2'd0;
    pulse_stop();
    n_cmp++; if (state !== 2'd3 || done !== 1'b1 || rd_en !== 1'b0 || fail !== 1'b0) begin n_bad++; $display("FAIL match_stop: got state=%0d done=%b rd_en=%b fail=%b want 3/1/0/0", state, done, rd_en, fail); end
  endtask

  task automatic test_mismatch();
    logic bad;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      bad = (i == 2 || i == 5 || i == 8);
      valid = 1'b1; exp_vec = 32'h3C3C_3C3C + i;
      dut_vec = bad ? (exp_vec ^ 32'h0008_0000) : exp_vec;
      cycle();
      n_cmp++; if (mismatch !== (bad ? 4'b0100 : 4'b0000)) begin n_bad++; $display("FAIL mis_pulse_%0d: got %b want %b", i, mismatch, bad ? 4'b0100 : 4'b0000); end
    end
    valid = 1'b0;
    ch_sel = 2'd2; #1;
    n_cmp++; if (ch_mismatch_cnt !== 16'd3 || ch_match_cnt !== 16'd7) begin n_bad++; $display("FAIL mis_ch2: got mis=%0d match=%0d want 3/7", ch_mismatch_cnt, ch_match_cnt); end
    ch_sel = 2'd0; #1;
    n_cmp++; if (ch_match_cnt !== 16'd10) begin n_bad++; $display("FAIL mis_ch0: got %0d want 10", ch_match_cnt); end
    n_cmp++; if (total_err !== 16'd3 || fail !== 1'b0) begin n_bad++; $display("FAIL mis_err_run: got err=%0d fail=%b want 3/0", total_err, fail); end
    pulse_stop();
    n_cmp++; if (fail !== 1'b1 || state !== 2'd3) begin n_bad++; $display("FAIL mis_fail: got fail=%b state=%0d want 1/3", fail, state); end
  endtask

  task automatic test_masked();
    pulse_start();
    exp_mask = 32'hFFFF_0FFF;
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; exp_vec = 32'h0F0F_0F0F ^ i; dut_vec = exp_vec ^ 32'h0000_F000; cycle();
    end
    valid = 1'b0; exp_mask = '1; ch_sel = 2'd1; #1;
    n_cmp++; if (ch_match_cnt !== 16'd5 || ch_mismatch_cnt !== 16'd0) begin n_bad++; $display("FAIL masked_ch1: got %0d/%0d want 5/0", ch_match_cnt, ch_mismatch_cnt); end
    n_cmp++; if (total_err !== 16'd0 || mismatch !== 4'd0) begin n_bad++; $display("FAIL masked_err: got err=%0d mis=%b want 0/0000", total_err, mismatch); end
    ch_sel = 2'd0;
    pulse_stop();
  endtask

  task automatic test_limit();
    max_err = 16'd5;
    pulse_start();
    exp_vec = 32'h5555_AAAA; dut_vec = exp_vec ^ 32'h8000_0001; valid = 1'b1;
    cycle();
    n_cmp++; if (total_err !== 16'd2 || state !== 2'd1) begin n_bad++; $display("FAIL limit_c1: got err=%0d state=%0d want 2/1", total_err, state); end
    cycle();
    stop = 1'b1; cycle(); stop = 1'b0;
    n_cmp++; if (state !== 2'd2 || rd_en !== 1'b0) begin n_bad++; $display("FAIL limit_state: got state=%0d rd_en=%b want 2/0", state, rd_en); end
    n_cmp++; if (total_err !== 16'd6 || total_txn !== 16'd3 || fail !== 1'b1) begin n_bad++; $display("FAIL limit_cnt: got err=%0d txn=%0d fail=%b want 6/3/1", total_err, total_txn, fail); end
    repeat (3) cycle();
    n_cmp++; if (total_err !== 16'd6 || total_txn !== 16'd3 || state !== 2'd2) begin n_bad++; $display("FAIL limit_frozen: got err=%0d txn=%0d state=%0d want 6/3/2", total_err, total_txn, state); end
    valid = 1'b0; max_err = 16'd0;
    pulse_stop();
    n_cmp++; if (state !== 2'd3 || done !== 1'b1 || fail !== 1'b1) begin n_bad++; $display("FAIL limit_done: got state=%0d done=%b fail=%b want 3/1/1", state, done, fail); end
  endtask

  task automatic test_timeout();
    pulse_start();
    exp_vec = 32'h0; dut_vec = 32'h1; valid = 1'b1; cycle(); cycle(); valid = 1'b0;
    repeat (97) cycle();
    n_cmp++; if (state !== 2'd1 || timed_out !== 1'b0) begin n_bad++; $display("FAIL to_cycle100: got state=%0d to=%b want 1/0", state, timed_out); end
    cycle();
    n_cmp++; if (state !== 2'd3 || timed_out !== 1'b1 || done !== 1'b1 || fail !== 1'b1) begin n_bad++; $display("FAIL to_done: got state=%0d to=%b done=%b fail=%b want 3/1/1/1", state, timed_out, done, fail); end
    pulse_start();
    n_cmp++; if (timed_out !== 1'b0 || total_txn !== 16'd0 || total_err !== 16'd0 || state !== 2'd1) begin n_bad++; $display("FAIL to_restart: got to=%b txn=%0d err=%0d state=%0d want 0/0/0/1", timed_out, total_txn, total_err, state); end
    pulse_stop();
  endtask

  task automatic test_saturate();
    pulse_start();
    exp_vec = 32'hDEAD_BEEF; dut_vec = exp_vec; valid = 1'b1;
    repeat (20) cycle();
    ch_sel = 2'd0; #1;
    n_cmp++; if (total_txn_s !== 4'd15 || ch_match_cnt_s !== 4'd15) begin n_bad++; $display("FAIL sat_match: got txn=%0d match=%0d want 15/15", total_txn_s, ch_match_cnt_s); end
    n_cmp++; if (total_txn !== 16'd20) begin n_bad++; $display("FAIL sat_wide_txn: got %0d want 20", total_txn); end
    dut_vec = ~exp_vec;
    repeat (4) cycle();
    valid = 1'b0;
    n_cmp++; if (total_err_s !== 4'd15 || ch_mismatch_cnt_s !== 4'd4) begin n_bad++; $display("FAIL sat_err: got err=%0d mis=%0d want 15/4", total_err_s, ch_mismatch_cnt_s); end
    n_cmp++; if (total_err !== 16'd16 || total_txn !== 16'd24) begin n_bad++; $display("FAIL sat_wide_err: got err=%0d txn=%0d want 16/24", total_err, total_txn); end
    pulse_stop();
  endtask

  task automatic test_start_stop_reset();
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL start_stop: got state=%0d want 1", state); end
    exp_vec = 32'h0; dut_vec = 32'h0000_0100; valid = 1'b1;
    repeat (3) cycle();
    valid = 1'b0;
    n_cmp++; if (total_txn !== 16'd3 || total_err !== 16'd3) begin n_bad++; $display("FAIL pre_reset: got txn=%0d err=%0d want 3/3", total_txn, total_err); end
    #2 reset_ = 1'b0; #1;
    n_cmp++; if (state !== 2'd0 || total_txn !== 16'd0 || total_err !== 16'd0 || rd_en !== 1'b0) begin n_bad++; $display("FAIL async_reset: got state=%0d txn=%0d err=%0d rd_en=%b want 0/0/0/0", state, total_txn, total_err, rd_en); end
    cycle(); reset_ = 1'b1; cycle();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL post_reset: got state=%0d want 0", state); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_masked();
    test_limit();
    test_timeout();
    test_saturate();
    test_start_stop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/vector_checker.md
# vector_checker

Parametrised, synthesisable expected-vector checker for the CSL-generated testbenches. Each valid cycle it compares up to N_CH DUT output channels against expected vectors under a per-bit compare mask, and keeps saturating per-channel match/mismatch counters plus global transaction and error totals. It drives the stimulus/expect memories' read enable and stops on a runtime error limit or a cycle timeout. It sits between the stim/expect vector memories and the DUT outputs, replacing the per-signal match/mismatch always blocks in the generated testbench.

## Interface
- N_CH, 4: number of compared channels
- WIDTH, 8: bits per channel
- CNT_WIDTH, 16: width of every counter
- CH_SEL_WIDTH, 2: width of ch_sel; 2**CH_SEL_WIDTH >= N_CH
- TIMEOUT_CYCLES, 100: maximum cycles spent in RUN; 0 disables the timeout

Ports:
- clock  in  1  single clock; all state changes on posedge
- reset_  in  1  asynchronous, active-low reset
- start  in  1  pulse: clear all counters, enter RUN
- stop  in  1  pulse: end the run
- valid  in  1  expected/stimulus vector valid (from vector memory)
- dut_vec  in  N_CH*WIDTH  DUT outputs; channel i = bits [i*WIDTH +: WIDTH]
- exp_vec  in  N_CH*WIDTH  expected vectors, same packing
- exp_mask  in  N_CH*WIDTH  1 = bit compared, 0 = don't-care
- max_err  in  CNT_WIDTH  error limit; 0 = unlimited
- ch_sel  in  CH_SEL_WIDTH  channel whose counters are shown
- rd_en  out  1  advance vector memories; high exactly when state==RUN
- mismatch  out  N_CH  registered per-channel mismatch pulse
- ch_match_cnt  out  CNT_WIDTH  match count of channel ch_sel (combinational mux); 0 if ch_sel >= N_CH
- ch_mismatch_cnt  out  CNT_WIDTH  mismatch count of channel ch_sel; 0 if ch_sel >= N_CH
- total_txn  out  CNT_WIDTH  compare cycles performed
- total_err  out  CNT_WIDTH  sum of channel mismatches, saturating
- state  out  2  IDLE=0, RUN=1, LIMIT=2, DONE=3
- done  out  1  state==DONE
- timed_out  out  1  sticky: the run ended by timeout
- fail  out  1  registered: state in {LIMIT, DONE} and total_err != 0

## Operation
- Reset (asynchronous, reset_ low): state=IDLE, all counters 0, cycle counter 0, mismatch=0, timed_out=0, fail=0. Outputs: rd_en=0, done=0.
- Compare: active when state==RUN and valid. Channel i mismatches if ((dut_i ^ exp_i) & mask_i) != 0; otherwise it matches. A fully masked channel always matches.
- On each compare:
  - every channel increments exactly one of its match or mismatch counters;
  - total_txn increments by 1;
  - total_err increments by the number of mismatching channels (0..N_CH).
  - All counters saturate at all-ones; they never wrap.
- State transitions:
  - start, from any state: clear all counters, the cycle counter and timed_out, then go to RUN. start has priority over stop, the limit and the timeout.
  - RUN → LIMIT: max_err != 0 and the post-update total_err >= max_err.
  - RUN → DONE: stop, or TIMEOUT_CYCLES != 0 and the cycle counter reaches TIMEOUT_CYCLES-1; a timeout also sets timed_out.
  - If LIMIT and DONE conditions occur in the same cycle, LIMIT wins.
  - LIMIT → DONE: on stop. No compares happen in LIMIT, and counters hold.
  - IDLE and DONE: hold until start.
- The cycle counter runs only in RUN and resets to 0 when RUN is entered.
- A compare on the same edge as a stop or timeout is still counted.

## Timing
- Counters and state update on the posedge where compare inputs are sampled, so they are visible 1 cycle after the valid cycle.
- mismatch[i] goes high for 1 cycle, in the cycle after the failing compare.
- rd_en decodes from the state register: it rises in the first cycle after the start edge and falls in the first cycle after the exit edge.
- fail and done reflect the new state in the cycle after a transition.
- Reset mid-run aborts the run immediately and asynchronously; no partial counts are kept.

## Test plan
- Reset with inputs active → state=0, rd_en=0, all counts 0. Then start, followed by 10 valid cycles with dut==exp → total_txn=10, each channel match=10, total_err=0, fail=0 after stop.
- N_CH=4: channel 2 differs in bit 3 for 3 compares, max_err=0 → ch_sel=2 gives mismatch=3, match=7; total_err=3; mismatch[2] pulses 3 times, each 1 cycle late; fail=1 after stop.
- Channel 1 differs only in masked bits (mask=8'h0F, diff=8'hF0) → no mismatches counted.
- max_err=5, two channels failing every cycle → total_err reaches 6 on the 3rd compare; state=LIMIT next cycle; rd_en=0; counts frozen; stop → DONE.
- TIMEOUT_CYCLES=100, no stop → DONE after exactly 100 RUN cycles with timed_out=1. A subsequent start clears timed_out and the counters.
- CNT_WIDTH=4, 20 matching compares → counters saturate at 15. Also: start and stop asserted in the same cycle → RUN. reset_ pulse mid-run → IDLE with all counts 0.
